icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped instruction cache sitting between the fetch stage and the instruction memory. Serves one 32-bit instruction per cycle on a hit. On a miss it stalls fetch, issues a line read to instruction memory over the Read/Ready handshake and installs the returned 4-word line. Fetch then re-presents the PC and hits.

## Interface
- `ICACHE_LINES`, default 4: number of lines; power of two, ≥2; `IDX_W = log2(ICACHE_LINES)`.
- `TAG_W`, default `` `WORD_SIZE``-4-`IDX_W`: tag width.
- `clk` in 1: single clock, posedge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: fetch presents `pc` this cycle.
- `pc` in `` `WORD_SIZE``: byte address; bits [1:0] ignored.
- `instr_valid` out 1: `instr` valid this cycle (hit).
- `instr` out `` `WORD_SIZE``: fetched word.
- `stall` out 1: fetch must hold `pc` and `req_valid`.
- `mem_read` out 1: read request to instruction memory.
- `mem_pc` out `` `WORD_SIZE``: registered miss address, line-aligned (bits [3:0] = 0).
- `mem_ready` in 1: instruction memory ready/done flag.
- `mem_line` in `` `ICACHE_LINE_SIZE``: returned line; word i at bits [32i+31:32i].
- `hit_count`, `miss_count` out 16: only when `ICACHE_STATS_EN` is defined.

## Operation
- Address split: word select = `pc[3:2]`, index = `pc[3+IDX_W:4]`, tag = `pc[WORD_SIZE-1:4+IDX_W]`.
- Arrays: `valid[ICACHE_LINES]`, `tag[ICACHE_LINES]`, `data[ICACHE_LINES]` (128 b).
- States: IDLE, REQ, WAIT.
- **IDLE**: combinational lookup. Hit is `req_valid & valid[idx] & tag match`.
  - Hit: `instr_valid=1`, `instr=data[idx][word]`, `stall=0`.
  - Miss with `req_valid`: `stall=1` in the same cycle; `mem_pc` ← `{pc[31:4],4'b0}`; go to REQ.
  - `req_valid=0`: all outputs idle.
- **REQ**: `mem_read=1` for exactly one cycle; `stall=1`; go to WAIT.
- **WAIT**: `mem_read=0`, `stall=1`.
  - `ready_q` holds `mem_ready` registered every cycle.
  - Completion is the rising edge: `mem_ready=1 & ready_q=0`.
  - On completion: `data[idx]` ← `mem_line`, `tag[idx]` ← miss tag, `valid[idx]` ← 1; go to IDLE.
- `mem_pc` stays stable from REQ until WAIT exits.
- Fetch must keep `pc` stable while `stall=1`. Tag and index for the fill come from `mem_pc`, never from live `pc`.
- A fill overwrites the indexed line regardless of its prior contents.
- The `pc` change on the cycle after a hit is unconstrained.

## Timing
- Reset values: state IDLE, all `valid`=0, `mem_read`=0, `mem_pc`=0, `ready_q`=0, `instr_valid`=0, `instr`=0, `stall`=0, counters=0.
- Hit latency: 0 cycles (combinational from `pc`).
- Miss: `stall` high from the miss cycle until WAIT completes, plus 1 cycle for the IDLE re-lookup (which hits).
- Miss penalty = 2 + memory latency cycles.
- Memory samples `mem_read` on negedge, so a one-cycle pulse is always accepted. Memory drops `mem_ready` before the posedge that ends REQ.
- A `mem_ready` rise is ignored outside WAIT.
- Reset mid-miss: aborts the miss and returns to IDLE. Instruction memory is not reset, so the system must hold `rst` low ≥16 cycles to let any in-flight memory transaction drain.
- Same-index back-to-back misses to different tags: each evicts the previous line. Always correct; no livelock because the re-lookup follows the fill immediately.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on each IDLE hit.
  - `miss_count` increments on each IDLE→REQ transition.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0.
  - The post-fill re-lookup counts as a hit.
- Undefined: the counter ports and logic are absent.

## Structure
- Shared `constants.v` holds `WORD_SIZE` (32) and `ICACHE_LINE_SIZE` (128), plus the new state encodings `ICACHE_IDLE`/`ICACHE_REQ`/`ICACHE_WAIT` (2 b).
- One natural sub-module: `icache_stats` (two saturating counters), instantiated only under `ICACHE_STATS_EN`.

## Test plan
- Reset, then `pc`=0x100 → miss: `stall`=1, one-cycle `mem_read`, `mem_pc`=0x100. Memory returns words A0..A3, then `instr_valid`=1 with `instr`=A0.
- After that fill, `pc`=0x104/0x108/0x10C → hits with no stall, returning A1, A2, A3 on consecutive cycles.
- `pc`=0x100 then `pc`=0x140 (same index at 4 lines, different tag) → second miss evicts the first. Re-fetching 0x100 misses again.
- `mem_ready` already 1 before the request → no false completion. Fill occurs only after the 0→1 transition.
- `rst` pulsed low during WAIT → `stall`=0, `mem_read`=0, all lines invalid. After 16 cycles, `pc`=0x100 misses and fills correctly.
- With `ICACHE_STATS_EN`: 1 miss + 4 hits gives `miss_count`=1, `hit_count`=5. Forcing past 0xFFFF hits holds `hit_count` at 0xFFFF.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the machine word size, the cache line size, the controller state
// encodings and a couple of small address/line helpers.
package icache_ctrl_pkg;

   localparam int WORD_SIZE        = 32;
   localparam int ICACHE_LINE_SIZE = 128;
   localparam int STATS_W          = 16;

   // Controller states: lookup, one-cycle memory request, wait for fill.
   typedef enum logic [1:0] {
      ICACHE_IDLE = 2'd0,
      ICACHE_REQ  = 2'd1,
      ICACHE_WAIT = 2'd2
   } icache_state_e;

   // Clear the byte/word offset so the address names the start of a line.
   function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] addr);
      return {addr[WORD_SIZE-1:4], 4'b0000};
   endfunction

   // Select one 32-bit word out of a 4-word line; word i lives at [32i+31:32i].
   function automatic logic [WORD_SIZE-1:0] line_word(input logic [ICACHE_LINE_SIZE-1:0] line,
                                                      input logic [1:0]                  sel);
      logic [WORD_SIZE-1:0] w;
      case (sel)
         2'd0:    w = line[31:0];
         2'd1:    w = line[63:32];
         2'd2:    w = line[95:64];
         default: w = line[127:96];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/icache_stats.sv
// Hit and miss event counters for the instruction cache.
// Both counters are 16 bits wide and saturate at 0xFFFF instead of wrapping.
module icache_stats
   import icache_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_hit,
   input  logic               i_miss,
   output logic [STATS_W-1:0] o_hit_count,
   output logic [STATS_W-1:0] o_miss_count
);

   logic [STATS_W-1:0] r_hit_count;
   logic [STATS_W-1:0] r_miss_count;

   // Count hits, holding at the all-ones ceiling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hit_count <= '0;
      end else if (i_hit && (r_hit_count != {STATS_W{1'b1}})) begin
         r_hit_count <= r_hit_count + 1'b1;
      end
   end

   // Count misses, holding at the all-ones ceiling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_miss_count <= '0;
      end else if (i_miss && (r_miss_count != {STATS_W{1'b1}})) begin
         r_miss_count <= r_miss_count + 1'b1;
      end
   end

   assign o_hit_count  = r_hit_count;
   assign o_miss_count = r_miss_count;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller.
// Serves one word per cycle on a hit (combinational lookup). On a miss it
// stalls fetch, pulses mem_read for one cycle, then waits for a rising edge
// of mem_ready and installs the returned 4-word line. Fetch re-presents the
// PC and the re-lookup hits.
// Optional feature: define ICACHE_STATS_EN to add saturating hit/miss
// counters (hit_count / miss_count ports and the icache_stats instance).
//
// Handshake: mem_read is a single-cycle request pulse issued from REQ;
// memory signals completion by raising mem_ready, and only a 0->1 transition
// of mem_ready seen while in WAIT completes the fill. A high level that was
// already present, or any rise outside WAIT, is ignored.
module icache_ctrl
   import icache_ctrl_pkg::*;
#(
   parameter int ICACHE_LINES = 4,
   parameter int TAG_W        = WORD_SIZE - 4 - $clog2(ICACHE_LINES)
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   input  logic [WORD_SIZE-1:0]        pc,
   output logic                        instr_valid,
   output logic [WORD_SIZE-1:0]        instr,
   output logic                        stall,
   output logic                        mem_read,
   output logic [WORD_SIZE-1:0]        mem_pc,
   input  logic                        mem_ready,
   input  logic [ICACHE_LINE_SIZE-1:0] mem_line
`ifdef ICACHE_STATS_EN
   ,
   output logic [STATS_W-1:0]          hit_count,
   output logic [STATS_W-1:0]          miss_count
`endif
);

   localparam int IDX_W = $clog2(ICACHE_LINES);

   // Controller state
   icache_state_e r_state;
   icache_state_e w_next_state;

   // Cache arrays
   logic [ICACHE_LINES-1:0]     r_valid;
   logic [TAG_W-1:0]            r_tag  [ICACHE_LINES];
   logic [ICACHE_LINE_SIZE-1:0] r_data [ICACHE_LINES];

   // Miss bookkeeping
   logic [WORD_SIZE-1:0] r_mem_pc;
   logic                 r_ready_q;

   // Lookup address split taken from the live PC
   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic [1:0]       w_word;

   // Fill address split taken from the registered miss address
   logic [IDX_W-1:0] w_fill_idx;
   logic [TAG_W-1:0] w_fill_tag;

   logic w_lookup_hit;
   logic w_hit;
   logic w_miss;
   logic w_fill_done;
   logic w_unused;

   assign w_idx      = pc[4 +: IDX_W];
   assign w_tag      = pc[4 + IDX_W +: TAG_W];
   assign w_word     = pc[3:2];
   assign w_fill_idx = r_mem_pc[4 +: IDX_W];
   assign w_fill_tag = r_mem_pc[4 + IDX_W +: TAG_W];

   assign w_lookup_hit = req_valid & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign w_hit        = (r_state == ICACHE_IDLE) & w_lookup_hit;
   assign w_miss       = (r_state == ICACHE_IDLE) & req_valid & ~w_lookup_hit;
   assign w_fill_done  = (r_state == ICACHE_WAIT) & mem_ready & ~r_ready_q;

   // Byte offset and the line offset of the miss address never affect state.
   assign w_unused = ^{pc[1:0], r_mem_pc[3:0], w_hit};

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ICACHE_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and fetch/memory-side outputs
   always_comb begin
      w_next_state = r_state;
      instr_valid  = 1'b0;
      instr        = '0;
      stall        = 1'b0;
      mem_read     = 1'b0;
      case (r_state)
         ICACHE_IDLE: begin
            if (w_lookup_hit) begin
               instr_valid = 1'b1;
               instr       = line_word(r_data[w_idx], w_word);
            end else if (req_valid) begin
               stall        = 1'b1;
               w_next_state = ICACHE_REQ;
            end
         end
         ICACHE_REQ: begin
            mem_read     = 1'b1;
            stall        = 1'b1;
            w_next_state = ICACHE_WAIT;
         end
         ICACHE_WAIT: begin
            stall = 1'b1;
            if (w_fill_done) begin
               w_next_state = ICACHE_IDLE;
            end
         end
         default: begin
            w_next_state = ICACHE_IDLE;
         end
      endcase
   end

   // Capture the line-aligned miss address; it stays put until the next miss.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_pc <= '0;
      end else if (w_miss) begin
         r_mem_pc <= line_align(pc);
      end
   end

   // Delayed copy of mem_ready for rising-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready_q <= 1'b0;
      end else begin
         r_ready_q <= mem_ready;
      end
   end

   // Valid bits: cleared on reset, set when a fill lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (w_fill_done) begin
         r_valid[w_fill_idx] <= 1'b1;
      end
   end

   // Tag and data arrays: a fill overwrites the indexed line unconditionally.
   always_ff @(posedge clk) begin
      if (w_fill_done) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= mem_line;
      end
   end

   assign mem_pc = r_mem_pc;

`ifdef ICACHE_STATS_EN
   icache_stats u_stats (
      .clk          (clk),
      .rst          (rst),
      .i_hit        (w_hit),
      .i_miss       (w_miss),
      .o_hit_count  (hit_count),
      .o_miss_count (miss_count)
   );
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: reset values, miss/fill sequence, hits on
// every word of a line, same-index eviction, mem_ready level vs edge, reset
// in the middle of a miss, and (with ICACHE_STATS_EN) the event counters.
module tb_icache_ctrl;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic [31:0]  pc;
   logic         instr_valid;
   logic [31:0]  instr;
   logic         stall;
   logic         mem_read;
   logic [31:0]  mem_pc;
   logic         mem_ready;
   logic [127:0] mem_line;
`ifdef ICACHE_STATS_EN
   logic [15:0]  hit_count;
   logic [15:0]  miss_count;
`endif

   int n_checks;
   int n_errors;

   localparam logic [127:0] LINE_A = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
   localparam logic [127:0] LINE_B = {32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};
   localparam logic [127:0] LINE_C = {32'hCCCC_0003, 32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};
   localparam logic [127:0] LINE_D = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};

   icache_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .pc          (pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .stall       (stall),
      .mem_read    (mem_read),
      .mem_pc      (mem_pc),
      .mem_ready   (mem_ready),
      .mem_line    (mem_line)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present a PC expected to hit; check the returned word, then take the edge.
   task automatic hit_chk(input logic [31:0] addr, input logic [31:0] exp_word);
      req_valid = 1'b1;
      pc        = addr;
      #1;
      check("hit_valid", {31'd0, instr_valid}, 32'd1);
      check("hit_instr", instr, exp_word);
      check("hit_stall", {31'd0, stall}, 32'd0);
      cyc();
   endtask

   // Full miss: stall in the miss cycle, one-cycle mem_read with the aligned
   // address, lat cycles in WAIT, rising mem_ready, then the re-lookup hit.
   task automatic miss_fill(input logic [31:0] addr, input logic [31:0] exp_mem_pc,
                            input logic [127:0] line, input int lat,
                            input logic [31:0] exp_word);
      req_valid = 1'b1;
      pc        = addr;
      #1;
      check("miss_stall", {31'd0, stall}, 32'd1);
      check("miss_no_instr", {31'd0, instr_valid}, 32'd0);
      check("miss_no_read", {31'd0, mem_read}, 32'd0);
      cyc();
      check("req_read", {31'd0, mem_read}, 32'd1);
      check("req_stall", {31'd0, stall}, 32'd1);
      check("req_mem_pc", mem_pc, exp_mem_pc);
      cyc();
      for (int i = 1; i < lat; i++) begin
         check("wait_read", {31'd0, mem_read}, 32'd0);
         check("wait_stall", {31'd0, stall}, 32'd1);
         cyc();
      end
      mem_line  = line;
      mem_ready = 1'b1;
      #1;
      check("done_stall", {31'd0, stall}, 32'd1);
      check("done_mem_pc", mem_pc, exp_mem_pc);
      cyc();
      mem_ready = 1'b0;
      hit_chk(addr, exp_word);
   endtask

   // Stimulus and checks
   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      req_valid = 1'b0;
      pc        = '0;
      mem_ready = 1'b0;
      mem_line  = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_read", {31'd0, mem_read}, 32'd0);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_mem_pc", mem_pc, 32'd0);
      rst = 1'b1;
      cyc();

      // Cold miss at 0x100, then the remaining words hit back to back
      miss_fill(32'h0000_0100, 32'h0000_0100, LINE_A, 3, 32'hAAAA_0000);
      hit_chk(32'h0000_0104, 32'hAAAA_0001);
      hit_chk(32'h0000_0108, 32'hAAAA_0002);
      hit_chk(32'h0000_010C, 32'hAAAA_0003);

      // Unaligned-in-line miss on index 1; index 0 stays intact
      miss_fill(32'h0000_0114, 32'h0000_0110, LINE_C, 1, 32'hCCCC_0001);
      hit_chk(32'h0000_0100, 32'hAAAA_0000);
      hit_chk(32'h0000_011C, 32'hCCCC_0003);

      // Same index, different tag: 0x140 evicts 0x100, which then misses again
      miss_fill(32'h0000_0140, 32'h0000_0140, LINE_B, 2, 32'hBBBB_0000);
      hit_chk(32'h0000_014C, 32'hBBBB_0003);
      miss_fill(32'h0000_0100, 32'h0000_0100, LINE_A, 2, 32'hAAAA_0000);

      // No request: outputs idle
      req_valid = 1'b0;
      #1;
      check("idle_stall", {31'd0, stall}, 32'd0);
      check("idle_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("idle_instr", instr, 32'd0);
      cyc();

      // mem_ready already high: the level must not complete the fill
      mem_ready = 1'b1;
      cyc();
      req_valid = 1'b1;
      pc        = 32'h0000_0208;
      mem_line  = LINE_D;
      #1;
      check("lvl_miss_stall", {31'd0, stall}, 32'd1);
      cyc();
      check("lvl_req_read", {31'd0, mem_read}, 32'd1);
      check("lvl_req_mem_pc", mem_pc, 32'h0000_0200);
      cyc();
      check("lvl_wait_stall0", {31'd0, stall}, 32'd1);
      cyc();
      check("lvl_wait_stall1", {31'd0, stall}, 32'd1);
      check("lvl_wait_instr_valid", {31'd0, instr_valid}, 32'd0);
      mem_ready = 1'b0;
      cyc();
      check("lvl_wait_stall2", {31'd0, stall}, 32'd1);
      mem_ready = 1'b1;
      cyc();
      mem_ready = 1'b0;
      hit_chk(32'h0000_0208, 32'hDDDD_0002);

      // Reset in the middle of a miss
      req_valid = 1'b1;
      pc        = 32'h0000_0300;
      cyc();
      cyc();
      #1;
      check("pre_rst_wait_stall", {31'd0, stall}, 32'd1);
      rst       = 1'b0;
      req_valid = 1'b0;
      #1;
      check("mid_rst_stall", {31'd0, stall}, 32'd0);
      check("mid_rst_read", {31'd0, mem_read}, 32'd0);
      check("mid_rst_mem_pc", mem_pc, 32'd0);
      repeat (16) cyc();
      rst = 1'b1;
      cyc();
      // Both lines that were valid before reset must miss now
      miss_fill(32'h0000_0114, 32'h0000_0110, LINE_C, 2, 32'hCCCC_0001);
      miss_fill(32'h0000_0100, 32'h0000_0100, LINE_A, 4, 32'hAAAA_0000);

`ifdef ICACHE_STATS_EN
      // Counters: one miss plus four more hits gives 1 miss and 5 hits
      req_valid = 1'b0;
      rst       = 1'b0;
      #1;
      check("stat_rst_hit", {16'd0, hit_count}, 32'd0);
      check("stat_rst_miss", {16'd0, miss_count}, 32'd0);
      cyc();
      rst = 1'b1;
      cyc();
      miss_fill(32'h0000_0100, 32'h0000_0100, LINE_A, 2, 32'hAAAA_0000);
      hit_chk(32'h0000_0104, 32'hAAAA_0001);
      hit_chk(32'h0000_0108, 32'hAAAA_0002);
      hit_chk(32'h0000_010C, 32'hAAAA_0003);
      hit_chk(32'h0000_0100, 32'hAAAA_0000);
      req_valid = 1'b0;
      #1;
      check("stat_hit", {16'd0, hit_count}, 32'd5);
      check("stat_miss", {16'd0, miss_count}, 32'd1);
      // Drive the hit counter past its ceiling
      req_valid = 1'b1;
      pc        = 32'h0000_0100;
      repeat (65535) cyc();
      check("stat_hit_sat", {16'd0, hit_count}, 32'h0000_FFFF);
      cyc();
      check("stat_hit_hold", {16'd0, hit_count}, 32'h0000_FFFF);
      check("stat_miss_keep", {16'd0, miss_count}, 32'd1);
      req_valid = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
